addr_seq_unlock: RTL and testbench

ADDR_SEQ_UNLOCK -- requirements
Module: addr_seq_unlock

---
 rtl/addr_seq_unlock.sv | 111 +++++++++++
 tb/tb_addr_seq_unlock.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/addr_seq_unlock.sv
// addr_seq_unlock: bus-address key-sequence lock. A window of read accesses
// whose key field matches KEY in order opens the block; any window write,
// an idle timeout or reset relocks it. Locked reads return LFSR noise.
module addr_seq_unlock #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [1:0]  WIN     = 2'b01,
  parameter int unsigned KEY_LSB = 4,
  parameter int unsigned KEY_W   = 4,
  parameter int unsigned KEY_LEN = 4,
  parameter logic [KEY_LEN*KEY_W-1:0] KEY = {4'hA, 4'h2, 4'h9, 4'h1},
  parameter int unsigned DATA_W  = 2,
  parameter logic [DATA_W-1:0] RESP = 2'b10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel_n,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       rd,
  input  logic                       strobe,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_oe,
  output logic                       unlocked,
  output logic [$clog2(KEY_LEN+1)-1:0] progress
);

  localparam int unsigned P_W   = $clog2(KEY_LEN + 1);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ARMING, OPEN} state_t;

  state_t             state;
  logic [P_W-1:0]     p;
  logic [CNT_W-1:0]   idle_cnt;
  logic [7:0]         lfsr;

  logic               hit;
  logic               qacc;
  logic               wacc;
  logic [KEY_W-1:0]   k;
  logic [KEY_W-1:0]   cur_key;
  logic [P_W-1:0]     p_adv;
  logic [7:0]         lfsr_nxt;
  logic               expire;
  logic               unused_addr;

  // Bus-cycle qualification and key field extraction
  assign hit  = strobe & ~sel_n & (addr[ADDR_W-1 -: 2] == WIN);
  assign qacc = hit & rd;
  assign wacc = hit & ~rd;
  assign k    = addr[KEY_LSB +: KEY_W];

  // Only the window bits and key field of the address carry meaning
  assign unused_addr = ^addr;

  // Fibonacci LFSR step, taps 8,6,5,4, shifting left into bit 0
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Idle expiry only matters once a sequence is in progress
  assign expire = (TIMEOUT != 0) && (p != '0) && (idle_cnt == CNT_W'(TIMEOUT));

  // Next progress value on a read: advance, restart on element 0, or clear
  always_comb begin
    cur_key = KEY[KEY_W-1:0];
    for (int i = 0; i < int'(KEY_LEN); i++) begin
      if (p == P_W'(i)) cur_key = KEY[i*KEY_W +: KEY_W];
    end
    if (k == cur_key)                    p_adv = p + P_W'(1);
    else if (k == KEY[KEY_W-1:0])        p_adv = P_W'(1);
    else                                 p_adv = '0;
  end

  // Lock state machine with idle counter and LFSR
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      p        <= '0;
      unlocked <= 1'b0;
      idle_cnt <= '0;
      lfsr     <= 8'h01;
    end else if (wacc) begin
      state    <= IDLE;
      p        <= '0;
      unlocked <= 1'b0;
      idle_cnt <= '0;
    end else if (qacc) begin
      idle_cnt <= '0;
      if (state != OPEN) begin
        lfsr     <= lfsr_nxt;
        p        <= p_adv;
        unlocked <= (p_adv == P_W'(KEY_LEN));
        if (p_adv == P_W'(KEY_LEN)) state <= OPEN;
        else if (p_adv == '0)       state <= IDLE;
        else                        state <= ARMING;
      end
    end else if (expire) begin
      state    <= IDLE;
      p        <= '0;
      unlocked <= 1'b0;
      idle_cnt <= '0;
    end else if (p != '0) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Read path reflects state before the access updates it
  assign rd_oe    = qacc;
  assign rd_data  = (state == OPEN) ? RESP : lfsr[DATA_W-1:0];
  assign progress = p;

endmodule

// File: tb/tb_addr_seq_unlock.sv
// Directed bench for addr_seq_unlock with a small LFSR reference model.
module tb_addr_seq_unlock;

  logic       clk;
  logic       rst;
  logic       sel_n;
  logic [13:0] addr;
  logic       rd;
  logic       strobe;
  logic [1:0] rd_data;
  logic       rd_oe;
  logic       unlocked;
  logic [2:0] progress;

  int nchk;
  int nfail;
  logic [7:0] m_lfsr;
  logic       m_open;

  addr_seq_unlock dut (
    .clk      (clk),
    .rst      (rst),
    .sel_n    (sel_n),
    .addr     (addr),
    .rd       (rd),
    .strobe   (strobe),
    .rd_data  (rd_data),
    .rd_oe    (rd_oe),
    .unlocked (unlocked),
    .progress (progress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobed bus cycle; checks read path before the edge, status after
  task automatic acc(input logic s_n, input logic [13:0] a, input logic r,
                     input logic [2:0] ep, input logic eu, input string tag);
    logic       eoe;
    logic [1:0] ed;
    @(negedge clk);
    sel_n = s_n; addr = a; rd = r; strobe = 1'b1;
    #1;
    eoe = !s_n && (a[13:12] == 2'b01) && r;
    chk({tag, ".oe"}, 32'(rd_oe), 32'(eoe));
    if (eoe) begin
      ed = m_open ? 2'b10 : m_lfsr[1:0];
      chk({tag, ".data"}, 32'(rd_data), 32'(ed));
      if (!m_open) m_lfsr = step(m_lfsr);
    end
    @(posedge clk);
    #1;
    strobe = 1'b0; sel_n = 1'b1;
    chk({tag, ".prog"}, 32'(progress), 32'(ep));
    chk({tag, ".unl"}, 32'(unlocked), 32'(eu));
    m_open = eu;
  endtask

  initial begin
    nchk = 0; nfail = 0;
    m_lfsr = 8'h01; m_open = 1'b0;
    rst = 1'b1; sel_n = 1'b1; addr = '0; rd = 1'b0; strobe = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.prog", 32'(progress), 32'd0);
    chk("rst.unl", 32'(unlocked), 32'd0);
    chk("rst.oe", 32'(rd_oe), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Full key sequence, then a read while open
    acc(1'b0, 14'h1010, 1'b1, 3'd1, 1'b0, "k1");
    acc(1'b0, 14'h1090, 1'b1, 3'd2, 1'b0, "k2");
    acc(1'b0, 14'h1020, 1'b1, 3'd3, 1'b0, "k3");
    acc(1'b0, 14'h10A0, 1'b1, 3'd4, 1'b1, "k4");
    acc(1'b0, 14'h1010, 1'b1, 3'd4, 1'b1, "open_rd");

    // Window write relocks; locked read returns LFSR bits
    acc(1'b0, 14'h1000, 1'b0, 3'd0, 1'b0, "wr_relock");
    acc(1'b0, 14'h1000, 1'b1, 3'd0, 1'b0, "locked_rd");

    // Mismatch on element 0 restarts at 1, then completes
    acc(1'b0, 14'h1010, 1'b1, 3'd1, 1'b0, "r1");
    acc(1'b0, 14'h1090, 1'b1, 3'd2, 1'b0, "r2");
    acc(1'b0, 14'h1010, 1'b1, 3'd1, 1'b0, "r_restart");
    acc(1'b0, 14'h1090, 1'b1, 3'd2, 1'b0, "r3");
    acc(1'b0, 14'h1020, 1'b1, 3'd3, 1'b0, "r4");
    acc(1'b0, 14'h10A0, 1'b1, 3'd4, 1'b1, "r5");
    acc(1'b0, 14'h1000, 1'b0, 3'd0, 1'b0, "wr2");

    // Non-key mismatch clears progress
    acc(1'b0, 14'h1010, 1'b1, 3'd1, 1'b0, "m1");
    acc(1'b0, 14'h1050, 1'b1, 3'd0, 1'b0, "m_clear");

    // Idle timeout relocks after 255 quiet cycles
    acc(1'b0, 14'h1010, 1'b1, 3'd1, 1'b0, "t1");
    acc(1'b0, 14'h1090, 1'b1, 3'd2, 1'b0, "t2");
    repeat (255) @(posedge clk);
    #1;
    chk("to.hold", 32'(progress), 32'd2);
    @(posedge clk);
    #1;
    chk("to.expire", 32'(progress), 32'd0);

    // Read on the expiry cycle wins over the timeout
    acc(1'b0, 14'h1010, 1'b1, 3'd1, 1'b0, "q1");
    acc(1'b0, 14'h1090, 1'b1, 3'd2, 1'b0, "q2");
    repeat (255) @(posedge clk);
    #1;
    chk("toq.hold", 32'(progress), 32'd2);
    acc(1'b0, 14'h1020, 1'b1, 3'd3, 1'b0, "toq.adv");
    acc(1'b0, 14'h1000, 1'b0, 3'd0, 1'b0, "wr3");

    // Deselected or out-of-window strobes are ignored
    acc(1'b1, 14'h1010, 1'b1, 3'd0, 1'b0, "ign_sel");
    acc(1'b0, 14'h3010, 1'b1, 3'd0, 1'b0, "ign_win");
    acc(1'b0, 14'h1000, 1'b1, 3'd0, 1'b0, "ign_lfsr");

    // Reset while open returns to idle with a fresh LFSR
    acc(1'b0, 14'h1010, 1'b1, 3'd1, 1'b0, "s1");
    acc(1'b0, 14'h1090, 1'b1, 3'd2, 1'b0, "s2");
    acc(1'b0, 14'h1020, 1'b1, 3'd3, 1'b0, "s3");
    acc(1'b0, 14'h10A0, 1'b1, 3'd4, 1'b1, "s4");
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst2.oe", 32'(rd_oe), 32'd0);
    @(posedge clk);
    #1;
    chk("rst2.prog", 32'(progress), 32'd0);
    chk("rst2.unl", 32'(unlocked), 32'd0);
    @(negedge clk); rst = 1'b0;
    m_lfsr = 8'h01; m_open = 1'b0;
    @(negedge clk);
    sel_n = 1'b0; addr = 14'h1000; rd = 1'b1; strobe = 1'b1;
    #1;
    chk("post_rst.data", 32'(rd_data), 32'd1);
    @(posedge clk);
    #1;
    strobe = 1'b0; sel_n = 1'b1;
    chk("post_rst.prog", 32'(progress), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
